bridge_controller: RTL and testbench

- Drawbridge sequencer: the consumer of the car counter's ExistCar output.
- Takes a boat request and the car-presence flag.
- Drives road light, road gate, bridge motor and boat light.
- Guarantees the bridge never moves while a car is on the deck; the car counter only reports deck occupancy, and this block acts on it.

---
 rtl/bridge_pkg.sv | 17 +
 rtl/bridge_if.sv | 23 ++
 rtl/bridge_timer.sv | 33 +++
 rtl/bridge_controller.sv | 196 +++++++++++++++++++
 tb/tb_bridge_controller.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/bridge_pkg.sv
// Shared types for the drawbridge sequencer: FSM state codes and road-light encodings.
package bridge_pkg;

  typedef enum logic [2:0] {
    ROAD_OPEN = 3'd0,
    WARN      = 3'd1,
    CLOSE     = 3'd2,
    RAISE     = 3'd3,
    OPEN      = 3'd4,
    LOWER     = 3'd5
  } state_e;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;

endpackage

// File: rtl/bridge_if.sv
// Boat/car inputs and light/gate/motor outputs of the drawbridge sequencer.
// slave = sequencer side, master = environment (sensors and actuators) side.
interface bridge_if;
  logic       BoatReq;
  logic       ExistCar;
  logic [1:0] CarLight;
  logic       GateClosed;
  logic       MotorUp;
  logic       MotorDown;
  logic       BoatGo;
  logic       Busy;
  logic       Fault;

  modport slave (
    input  BoatReq, ExistCar,
    output CarLight, GateClosed, MotorUp, MotorDown, BoatGo, Busy, Fault
  );

  modport master (
    output BoatReq, ExistCar,
    input  CarLight, GateClosed, MotorUp, MotorDown, BoatGo, Busy, Fault
  );
endinterface

// File: rtl/bridge_timer.sv
// Loadable down-counter shared by all timed sequencer states; holds at zero.
module bridge_timer #(
  parameter int TW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          zero_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bridge_controller.sv
// Drawbridge sequencer: road light, gate, bridge motor and boat light from BoatReq/ExistCar.
// Optional build macro BRIDGE_CLEAR_TIMEOUT_EN aborts CLOSE back to ROAD_OPEN on a stuck deck.
module bridge_controller
  import bridge_pkg::*;
#(
  parameter int WARN_TICKS     = 4,
  parameter int MOVE_TICKS     = 8,
  parameter int OPEN_MIN_TICKS = 6,
  parameter int CLEAR_TIMEOUT  = 32,
  parameter int TW             = 8
) (
  input  logic     Clk,
  input  logic     Reset,
  bridge_if.slave  bus
);

  localparam logic [2:0] S_ROAD_OPEN = ROAD_OPEN;
  localparam logic [2:0] S_WARN      = WARN;
  localparam logic [2:0] S_CLOSE     = CLOSE;
  localparam logic [2:0] S_RAISE     = RAISE;
  localparam logic [2:0] S_OPEN      = OPEN;
  localparam logic [2:0] S_LOWER     = LOWER;

  // Timer loads N-1 on entry so a state with duration N is held exactly N cycles.
  localparam logic [TW-1:0] WARN_LD = TW'(WARN_TICKS - 1);
  localparam logic [TW-1:0] MOVE_LD = TW'(MOVE_TICKS - 1);
  localparam logic [TW-1:0] OPEN_LD = TW'(OPEN_MIN_TICKS - 1);

  localparam bit PARAMS_OK = (WARN_TICKS >= 1) && (MOVE_TICKS >= 1) && (OPEN_MIN_TICKS >= 1) &&
                             (CLEAR_TIMEOUT >= 1) &&
                             (WARN_TICKS < 2**TW) && (MOVE_TICKS < 2**TW) &&
                             (OPEN_MIN_TICKS < 2**TW) && (CLEAR_TIMEOUT < 2**TW);

  if (!PARAMS_OK) begin : g_param_check
    $error("bridge_controller: tick parameters must be >= 1 and < 2**TW");
  end

  logic [2:0]    state_q, state_d;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic          req_blocked;

  logic [1:0] light_q, light_d;
  logic       gate_q, gate_d;
  logic       up_q, up_d;
  logic       down_q, down_d;
  logic       go_q, go_d;
  logic       busy_q, busy_d;

`ifdef BRIDGE_CLEAR_TIMEOUT_EN
  localparam logic [TW-1:0] CLEAR_LD = TW'(CLEAR_TIMEOUT - 1);
  logic fault_q, fault_d;
`endif

  bridge_timer #(
    .TW(TW)
  ) u_timer (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
`ifdef BRIDGE_CLEAR_TIMEOUT_EN
    fault_d  = 1'b0;
`endif
    case (state_q)
      S_ROAD_OPEN: begin
        if (bus.BoatReq && !req_blocked) begin
          state_d  = S_WARN;
          tmr_load = 1'b1;
          tmr_val  = WARN_LD;
        end
      end
      S_WARN: begin
        if (tmr_zero) begin
          state_d  = S_CLOSE;
`ifdef BRIDGE_CLEAR_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = CLEAR_LD;
`endif
        end
      end
      S_CLOSE: begin
        // A clear deck on the expiry cycle still wins over the timeout.
        if (!bus.ExistCar) begin
          state_d  = S_RAISE;
          tmr_load = 1'b1;
          tmr_val  = MOVE_LD;
        end
`ifdef BRIDGE_CLEAR_TIMEOUT_EN
        else if (tmr_zero) begin
          state_d = S_ROAD_OPEN;
          fault_d = 1'b1;
        end
`endif
      end
      S_RAISE: begin
        if (tmr_zero) begin
          state_d  = S_OPEN;
          tmr_load = 1'b1;
          tmr_val  = OPEN_LD;
        end
      end
      S_OPEN: begin
        if (tmr_zero && !bus.BoatReq) begin
          state_d  = S_LOWER;
          tmr_load = 1'b1;
          tmr_val  = MOVE_LD;
        end
      end
      S_LOWER: begin
        if (tmr_zero) begin
          state_d = S_ROAD_OPEN;
        end
      end
      default: state_d = S_ROAD_OPEN;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they track state_q exactly.
  always_comb begin
    light_d = LIGHT_RED;
    gate_d  = 1'b1;
    up_d    = 1'b0;
    down_d  = 1'b0;
    go_d    = 1'b0;
    busy_d  = 1'b1;
    case (state_d)
      S_ROAD_OPEN: begin
        light_d = LIGHT_GREEN;
        gate_d  = 1'b0;
        busy_d  = 1'b0;
      end
      S_WARN: begin
        light_d = LIGHT_YELLOW;
        gate_d  = 1'b0;
      end
      S_RAISE: up_d   = 1'b1;
      S_OPEN:  go_d   = 1'b1;
      S_LOWER: down_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_ROAD_OPEN;
      light_q <= LIGHT_GREEN;
      gate_q  <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      light_q <= light_d;
      gate_q  <= gate_d;
      up_q    <= up_d;
      down_q  <= down_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
    end
  end

`ifdef BRIDGE_CLEAR_TIMEOUT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  // The fault cycle doubles as the one-cycle lockout of a fresh boat request.
  assign req_blocked = fault_q;
  assign bus.Fault   = fault_q;
`else
  assign req_blocked = 1'b0;
  assign bus.Fault   = 1'b0;
`endif

  assign bus.CarLight   = light_q;
  assign bus.GateClosed = gate_q;
  assign bus.MotorUp    = up_q;
  assign bus.MotorDown  = down_q;
  assign bus.BoatGo     = go_q;
  assign bus.Busy       = busy_q;

endmodule

// File: tb/tb_bridge_controller.sv
// Bench for bridge_controller: table-driven full cycle, hand-written corner sequences and
// randomized traffic checked against a phase/elapsed-time model of the drawbridge rules.
module tb_bridge_controller;

  localparam int WARN_T  = 3;
  localparam int MOVE_T  = 4;
  localparam int OPEN_T  = 5;
  localparam int CLEAR_T = 10;

`ifdef BRIDGE_CLEAR_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
  localparam int CAR_FALL   = 8;
`else
  localparam bit TIMEOUT_EN = 1'b0;
  localparam int CAR_FALL   = 20;
`endif

  // Observation vector: {CarLight[1:0], GateClosed, MotorUp, MotorDown, BoatGo, Busy, Fault}
  localparam logic [7:0] V_IDLE = 8'b00_0_0_0_0_0_0;
  localparam logic [7:0] V_YEL  = 8'b01_0_0_0_0_1_0;
  localparam logic [7:0] V_RED  = 8'b10_1_0_0_0_1_0;
  localparam logic [7:0] V_UP   = 8'b10_1_1_0_0_1_0;
  localparam logic [7:0] V_GO   = 8'b10_1_0_0_1_1_0;
  localparam logic [7:0] V_DN   = 8'b10_1_0_1_0_1_0;
  localparam logic [7:0] V_FLT  = 8'b00_0_0_0_0_0_1;

  logic Clk;
  logic Reset;
  bridge_if bus ();

  bridge_controller #(
    .WARN_TICKS     (WARN_T),
    .MOVE_TICKS     (MOVE_T),
    .OPEN_MIN_TICKS (OPEN_T),
    .CLEAR_TIMEOUT  (CLEAR_T),
    .TW             (8)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] obs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: which phase the bridge is in and how many cycles it has been there.
  typedef enum int {M_ROAD, M_WARN, M_CLOSE, M_RAISE, M_OPEN, M_LOWER} mph_e;
  mph_e m_ph = M_ROAD;
  int   m_el = 1;
  bit   m_fault = 1'b0;

  task automatic model_step(input bit rst, input bit boat, input bit car);
    mph_e nx;
    bit   f;
    nx = m_ph;
    f  = 1'b0;
    if (rst) begin
      m_ph = M_ROAD;
      m_el = 1;
      m_fault = 1'b0;
      return;
    end
    case (m_ph)
      M_ROAD:  if (boat && !m_fault) nx = M_WARN;
      M_WARN:  if (m_el == WARN_T) nx = M_CLOSE;
      M_CLOSE: if (!car) nx = M_RAISE;
               else if (TIMEOUT_EN && m_el == CLEAR_T) begin nx = M_ROAD; f = 1'b1; end
      M_RAISE: if (m_el == MOVE_T) nx = M_OPEN;
      M_OPEN:  if (m_el >= OPEN_T && !boat) nx = M_LOWER;
      M_LOWER: if (m_el == MOVE_T) nx = M_ROAD;
      default: nx = M_ROAD;
    endcase
    m_el    = (nx != m_ph) ? 1 : m_el + 1;
    m_ph    = nx;
    m_fault = f;
  endtask

  function automatic logic [7:0] model_exp();
    case (m_ph)
      M_ROAD:  return m_fault ? V_FLT : V_IDLE;
      M_WARN:  return V_YEL;
      M_CLOSE: return V_RED;
      M_RAISE: return V_UP;
      M_OPEN:  return V_GO;
      default: return V_DN;
    endcase
  endfunction

  // Drive one cycle of inputs, then sample the outputs of the following cycle.
  task automatic tick(input bit rst, input bit boat, input bit car);
    Reset = rst;
    bus.BoatReq = boat;
    bus.ExistCar = car;
    @(posedge Clk);
    model_step(rst, boat, car);
    #1;
    obs = {bus.CarLight, bus.GateClosed, bus.MotorUp, bus.MotorDown, bus.BoatGo, bus.Busy, bus.Fault};
    check("model", {24'd0, obs}, {24'd0, model_exp()});
    check("inv_motors", {31'd0, bus.MotorUp & bus.MotorDown}, 32'd0);
    if (bus.MotorUp | bus.MotorDown | bus.BoatGo)
      check("inv_road_blocked", {29'd0, bus.GateClosed, bus.CarLight}, {29'd0, 1'b1, 2'b10});
  endtask

  typedef struct {
    int         n;
    bit         boat;
    bit         car;
    logic [7:0] exp;
  } row_t;

  row_t tbl[8];

  initial begin
    int cnt;

    // Each row: inputs held for n cycles, exp is the output seen one cycle after each.
    tbl[0] = '{1, 1'b1, 1'b0, V_YEL};
    tbl[1] = '{2, 1'b1, 1'b0, V_YEL};
    tbl[2] = '{1, 1'b1, 1'b0, V_RED};
    tbl[3] = '{4, 1'b1, 1'b0, V_UP};
    tbl[4] = '{4, 1'b1, 1'b0, V_GO};
    tbl[5] = '{1, 1'b0, 1'b0, V_GO};
    tbl[6] = '{4, 1'b0, 1'b0, V_DN};
    tbl[7] = '{2, 1'b0, 1'b0, V_IDLE};

    Reset = 1'b1;
    bus.BoatReq = 1'b0;
    bus.ExistCar = 1'b0;

    // Reset and idle
    tick(1, 0, 0);
    tick(1, 0, 0);
    check("reset_state", {24'd0, obs}, {24'd0, V_IDLE});
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0);
      check("idle", {24'd0, obs}, {24'd0, V_IDLE});
    end

    // Full raise/lower cycle from the table
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        tick(0, tbl[r].boat, tbl[r].car);
        check($sformatf("table_row%0d", r), {24'd0, obs}, {24'd0, tbl[r].exp});
      end
    end

    // Occupied deck: CLOSE holds until ExistCar falls
    for (int k = 0; k <= CAR_FALL; k++) begin
      tick(0, 1, (k < CAR_FALL));
      if (k == CAR_FALL - 1) check("occupied_hold", {24'd0, obs}, {24'd0, V_RED});
      if (k == CAR_FALL)     check("occupied_raise", {24'd0, obs}, {24'd0, V_UP});
    end
    for (int k = 0; k < 20; k++) tick(0, 0, 0);
    check("occupied_done", {24'd0, obs}, {24'd0, V_IDLE});

    // Long boat: BoatReq held 30 cycles
    for (int k = 0; k < 30; k++) tick(0, 1, 0);
    check("long_boat_go", {24'd0, obs}, {24'd0, V_GO});
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick(0, 0, 0);
      if (k == 0) check("long_boat_lower", {24'd0, obs}, {24'd0, V_DN});
      cnt += int'(obs[3]);
    end
    check("long_boat_down_cycles", cnt, MOVE_T);
    check("long_boat_done", {24'd0, obs}, {24'd0, V_IDLE});

    // Reset asserted mid-RAISE
    for (int k = 0; k < 6; k++) tick(0, 1, 0);
    check("pre_reset_raise", {24'd0, obs}, {24'd0, V_UP});
    tick(1, 0, 0);
    check("reset_mid_raise", {24'd0, obs}, {24'd0, V_IDLE});
    tick(0, 0, 0);
    check("after_reset_raise", {24'd0, obs}, {24'd0, V_IDLE});

    // Stuck deck
    cnt = 0;
`ifdef BRIDGE_CLEAR_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      tick(0, 1, 1);
      cnt += int'(obs[0]);
      if (k == 12) check("timeout_close", {24'd0, obs}, {24'd0, V_RED});
      if (k == 13) check("timeout_fault", {24'd0, obs}, {24'd0, V_FLT});
      if (k == 14) check("timeout_lockout", {24'd0, obs}, {24'd0, V_IDLE});
      if (k == 15) check("timeout_rerequest", {24'd0, obs}, {24'd0, V_YEL});
    end
    check("timeout_fault_count", cnt, 1);
`else
    for (int k = 0; k < 104; k++) begin
      tick(0, 1, 1);
      cnt += int'(obs[0]);
      if (k >= 3 && obs !== V_RED) cnt += 100;
    end
    check("stuck_deck_hold", cnt, 0);
`endif
    for (int k = 0; k < 30; k++) tick(0, 0, 0);
    check("stuck_deck_drain", {24'd0, obs}, {24'd0, V_IDLE});

    // Randomized traffic against the model
    begin
      bit boat, car, rst;
      boat = 1'b0;
      car  = 1'b0;
      for (int k = 0; k < 1500; k++) begin
        if ($urandom_range(0, 7) == 0) boat = ~boat;
        if ($urandom_range(0, 5) == 0) car = ~car;
        rst = ($urandom_range(0, 299) == 0);
        tick(rst, boat, car);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
